// File: rtl/stream_mux_rr_pkg.sv
// rtl/stream_mux_rr_pkg.sv - shared constants and helpers for the streaming N:1 mux
package stream_mux_rr_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Modular add for channel indices; keeps every index below n for any n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - round-robin arbiter with explicit pointer wrap
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int N    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            adv,
    output logic [SELW-1:0] gnt,
    output logic            gnt_v
);

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] idx;

    // Scan ptr, ptr+1, .. wrapping at N; the first requester found wins.
    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = SELW'(wrap_add(int'(ptr), k, N));
            if (!gnt_v && req[idx]) begin
                gnt_v = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel valid/ready stream mux with registered output slice
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int MODE = MODE_SEL,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    input  logic            out_ready
);

    logic            load_en;
    logic            xfer;
    logic            gnt_v;
    logic [SELW-1:0] gnt;

    assign load_en = !out_valid || out_ready;
    assign xfer    = load_en && gnt_v;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .N    (N),
                .SELW (SELW)
            ) u_arb (
                .clk   (clk),
                .rst   (rst),
                .req   (in_valid),
                .adv   (xfer),
                .gnt   (gnt),
                .gnt_v (gnt_v)
            );
            logic unused_sel;
            assign unused_sel = ^sel;
        end else begin : g_sel
            // Compare one bit wider so an out-of-range sel is caught even when N = 2**SELW.
            localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);
            assign gnt   = sel;
            assign gnt_v = ({1'b0, sel} < N_EXT) && in_valid[sel];
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt] = 1'b1;
        end
    end

    // A new word replaces the held one on a simultaneous drain; a lone drain keeps data/sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt*W +: W];
            out_sel   <= gnt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
